// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box table, GF(2^8) doubling, controller state encoding,
// and flat <-> row/column state conversions used around the round datapath.
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  // State matrix indexed [row][col]; FIPS byte i sits at row i%4, column i/4.
  typedef logic [3:0][3:0][7:0] aes_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_state_t to_state(input logic [127:0] flat);
    aes_state_t s;
    logic [127:0] t;
    t = flat;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s[r[1:0]][c[1:0]] = t[127:120];
        t = t << 8;
      end
    end
    return s;
  endfunction

  function automatic logic [127:0] to_flat(input aes_state_t s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t = {t[119:0], s[r[1:0]][c[1:0]]};
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: next round key from the current one and rcon.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_rot;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = rk[127:96];
  assign w1 = rk[95:64];
  assign w2 = rk[63:32];
  assign w3 = rk[31:0];

  // RotWord moves the top byte to the bottom, then each byte goes through the S-box.
  assign sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

  assign n0 = w0 ^ sub_rot ^ {rcon, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_round_ctrl.sv
// Sequencer for a shared AES round datapath performing a full AES-128 encryption.
//
// state | meaning
// IDLE  | waiting for plaintext+key, in_ready high
// KEY   | derive next round key, latch round inputs for the datapath
// ROUND | datapath busy for ROUND_LAT cycles, capture result on the last one
// DONE  | ciphertext presented until the consumer takes it
module aes128_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR        = 10,
  parameter int ROUND_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] block_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] block_out,
  output logic [127:0] rnd_in,
  output logic [127:0] rnd_key,
  output logic         rnd_last,
  input  logic [127:0] rnd_out,
  output logic         busy,
  output logic [3:0]   round_cnt
);

  localparam logic [3:0] NR_CNT   = 4'(NR);
  localparam logic [1:0] LAT_LOAD = 2'(ROUND_LAT - 1);

  ctrl_state_e  state, state_nxt;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] rk_next;
  logic [7:0]   rcon;
  logic [3:0]   cnt;
  logic [1:0]   lat_cnt;
  logic         round_done;

  aes_key_step u_key_step (
    .rk      (rk),
    .rcon    (rcon),
    .rk_next (rk_next)
  );

  // Datapath result is ready once the latency down-counter reaches terminal count.
  assign round_done = (state == ROUND) && (lat_cnt == 2'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (in_valid) state_nxt = KEY;
      KEY:   state_nxt = ROUND;
      ROUND: if (round_done) state_nxt = (cnt == NR_CNT) ? DONE : KEY;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    block_out = (state == DONE) ? st : '0;
    round_cnt = ((state == KEY) || (state == ROUND)) ? cnt : 4'd0;
  end

  // Cipher state, key schedule, counters and registered round-datapath inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= '0;
      rk       <= '0;
      rcon     <= 8'h01;
      cnt      <= 4'd0;
      lat_cnt  <= 2'd0;
      rnd_in   <= '0;
      rnd_key  <= '0;
      rnd_last <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st   <= block_in ^ key_in;
            rk   <= key_in;
            rcon <= 8'h01;
            cnt  <= 4'd1;
          end
        end
        KEY: begin
          rk       <= rk_next;
          rcon     <= xtime(rcon);
          rnd_in   <= st;
          rnd_key  <= rk_next;
          rnd_last <= (cnt == NR_CNT);
          lat_cnt  <= LAT_LOAD;
        end
        ROUND: begin
          if (lat_cnt == 2'd0) begin
            st <= rnd_out;
            if (cnt != NR_CNT) cnt <= cnt + 4'd1;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl with a single-cycle round datapath model behind it.
module tb_aes128_round_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] PT1   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] block_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] block_out;
  logic [127:0] rnd_in;
  logic [127:0] rnd_key;
  logic         rnd_last;
  logic [127:0] rnd_out;
  logic         busy;
  logic [3:0]   round_cnt;

  int n_chk = 0;
  int n_bad = 0;
  logic [127:0] sb_q[$];

  always #5 clk = ~clk;

  aes128_round_ctrl #(.NR(10), .ROUND_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .block_in  (block_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .block_out (block_out),
    .rnd_in    (rnd_in),
    .rnd_key   (rnd_key),
    .rnd_last  (rnd_last),
    .rnd_out   (rnd_out),
    .busy      (busy),
    .round_cnt (round_cnt)
  );

  // Round datapath: SubBytes, ShiftRows, MixColumns (skipped on last), AddRoundKey.
  function automatic logic [127:0] round_fn(input logic [127:0] s_in, input logic [127:0] k,
                                            input logic last);
    aes_state_t s, t;
    logic [7:0] a0, a1, a2, a3;
    s = to_state(s_in);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int cc;
        cc = (c + r) % 4;
        t[r[1:0]][c[1:0]] = sbox(s[r[1:0]][cc[1:0]]);
      end
    end
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[0][c[1:0]]; a1 = t[1][c[1:0]]; a2 = t[2][c[1:0]]; a3 = t[3][c[1:0]];
        t[0][c[1:0]] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[1][c[1:0]] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[2][c[1:0]] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[3][c[1:0]] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return to_flat(t) ^ k;
  endfunction

  assign rnd_out = round_fn(rnd_in, rnd_key, rnd_last);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each ciphertext transfer against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_underflow", 128'(sb_q.size()), 128'd1);
      else                  chk("ct", block_out, sb_q.pop_front());
    end
  end

  // Offer a block; called just after a rising edge, returns just after the accept edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    block_in = pt;
    key_in   = key;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        sb_q.push_back(exp);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 128'(in_ready), 128'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain", 128'(sb_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    block_in  = '0;
    key_in    = '0;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_round_cnt", 128'(round_cnt), 128'd0);
    chk("rst_block_out", block_out, 128'd0);
    chk("rst_rnd_in", rnd_in, 128'd0);
    chk("rst_rnd_key", rnd_key, 128'd0);
    chk("rst_rnd_last", 128'(rnd_last), 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;

    // Case 1 with round-key trace, exact latency, and noisy inputs while busy
    send(PT1, KEY1, CT1);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      chk("trace_round_cnt", 128'(round_cnt), 128'(cyc / 2 + 1));
      chk("trace_out_valid", 128'(out_valid), 128'd0);
      chk("trace_in_ready", 128'(in_ready), 128'd0);
      if (cyc % 2 == 1) begin
        chk("trace_rnd_last", 128'(rnd_last), 128'(cyc == 19));
        if (cyc == 1)  chk("trace_rk1", rnd_key, RK1);
        if (cyc == 19) chk("trace_rk10", rnd_key, RK10);
      end
      @(posedge clk);
      #1;
      block_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid = (cyc < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    chk("lat_out_valid", 128'(out_valid), 128'd1);
    chk("done_round_cnt", 128'(round_cnt), 128'd0);
    @(negedge clk);
    chk("done_one_cycle", 128'(out_valid), 128'd0);
    chk("rearm_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;

    // Case 2
    send(PT2, KEY2, CT2);
    drain();

    // Backpressure in DONE, new offer held off until after the transfer
    out_ready = 1'b0;
    send(PT1, KEY1, CT1);
    for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_block_out", block_out, CT1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1;
      if (i == 1) begin
        in_valid = 1'b1;
        block_in = PT2;
        key_in   = KEY2;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_busy", 128'(busy), 128'd0);
    chk("bp_idle_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    sb_q.push_back(CT2);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_busy", 128'(busy), 128'd1);
    chk("bp_next_round_cnt", 128'(round_cnt), 128'd1);
    drain();

    // Reset mid-operation, then a clean rerun
    send(PT1, KEY1, CT1);
    for (int i = 0; i < 40 && round_cnt != 4'd5; i++) @(negedge clk);
    chk("abort_at_rc5", 128'(round_cnt), 128'd5);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_round_cnt", 128'(round_cnt), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    send(PT2, KEY2, CT2);
    drain();

    // Back-to-back with out_ready held high
    send(PT1, KEY1, CT1);
    send(PT2, KEY2, CT2);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
